// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared widths and latency for the mult_16bit multiplier.
//               Latency follows the MULT_16BIT_PIPE_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_W = 16;
    localparam int PROD_W = 32;

`ifdef MULT_16BIT_PIPE_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_16bit_if.sv
// ============================================================================
// Module      : mult_16bit_if
// Description : Operand/product bundle for mult_16bit; master drives operands,
//               slave (the multiplier) returns the product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_16bit_if;
    import mult_pkg::*;

    logic              in_valid;
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
    logic              out_valid;
    logic [PROD_W-1:0] p;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  p
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output p
    );

endinterface : mult_16bit_if

`default_nettype wire

// File: rtl/mult_add_row.sv
// ============================================================================
// Module      : mult_add_row
// Description : One 16-bit ripple-carry reduction row of the array multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_add_row
    import mult_pkg::*;
(
    input  wire logic [MULT_W-1:0] prev_sum,
    input  wire logic [MULT_W-1:0] pp,
    input  wire logic              cin,
    output logic      [MULT_W-1:0] sum,
    output logic                   cout,
    output logic                   lsb
);

    logic [MULT_W:0] carry;

    assign carry[0] = cin;

    for (genvar j = 0; j < MULT_W; j++) begin : g_fa
        assign sum[j]     = prev_sum[j] ^ pp[j] ^ carry[j];
        assign carry[j+1] = (prev_sum[j] & pp[j]) | (carry[j] & (prev_sum[j] ^ pp[j]));
    end

    assign cout = carry[MULT_W];
    assign lsb  = sum[0];

endmodule : mult_add_row

`default_nettype wire

// File: rtl/mult_16bit.sv
// ============================================================================
// Module      : mult_16bit
// Description : Registered 16x16 unsigned array multiplier, 32-bit product.
//               Define MULT_16BIT_PIPE_EN to register the array after row 7.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_16bit
    import mult_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    mult_16bit_if.slave bus
);

    localparam int CUT = 8;

    logic [MULT_W-1:0] row_sum  [0:MULT_W-1];
    logic              row_cout [0:MULT_W-1];
    logic [MULT_W-1:0] row_lsb;

    // Values seen by rows CUT..15: registered in the pipelined build, direct otherwise.
    logic [MULT_W-1:0] stage_sum;
    logic              stage_carry;
    logic [CUT-1:0]    stage_low;
    logic [MULT_W-1:CUT] stage_b_hi;
    logic [MULT_W-1:0] stage_a;
    logic              stage_valid;

    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] p_q;
    logic              valid_q;

    assign row_sum[0]  = bus.a & {MULT_W{bus.b[0]}};
    assign row_cout[0] = 1'b0;
    assign row_lsb[0]  = row_sum[0][0];

    for (genvar i = 1; i < MULT_W; i++) begin : g_row
        logic [MULT_W-1:0] prev;
        logic [MULT_W-1:0] pp;

        // Previous sum drops its emitted LSB; the carry-out becomes the new MSB.
        if (i == CUT) begin : g_cut
            assign prev = {stage_carry, stage_sum[MULT_W-1:1]};
        end else begin : g_chain
            assign prev = {row_cout[i-1], row_sum[i-1][MULT_W-1:1]};
        end

        if (i >= CUT) begin : g_hi
            assign pp = stage_a & {MULT_W{stage_b_hi[i]}};
        end else begin : g_lo
            assign pp = bus.a & {MULT_W{bus.b[i]}};
        end

        mult_add_row u_row (
            .prev_sum (prev),
            .pp       (pp),
            .cin      (1'b0),
            .sum      (row_sum[i]),
            .cout     (row_cout[i]),
            .lsb      (row_lsb[i])
        );
    end

`ifdef MULT_16BIT_PIPE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_sum   <= '0;
            stage_carry <= 1'b0;
            stage_low   <= '0;
            stage_b_hi  <= '0;
            stage_a     <= '0;
            stage_valid <= 1'b0;
        end else begin
            stage_sum   <= row_sum[CUT-1];
            stage_carry <= row_cout[CUT-1];
            stage_low   <= row_lsb[CUT-1:0];
            stage_b_hi  <= bus.b[MULT_W-1:CUT];
            stage_a     <= bus.a;
            stage_valid <= bus.in_valid;
        end
    end
`else
    assign stage_sum   = row_sum[CUT-1];
    assign stage_carry = row_cout[CUT-1];
    assign stage_low   = row_lsb[CUT-1:0];
    assign stage_b_hi  = bus.b[MULT_W-1:CUT];
    assign stage_a     = bus.a;
    assign stage_valid = bus.in_valid;
`endif

    assign product = {row_cout[MULT_W-1], row_sum[MULT_W-1][MULT_W-1:1],
                      row_lsb[MULT_W-1:CUT], stage_low};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= stage_valid;
            if (stage_valid) begin
                p_q <= product;
            end
        end
    end

    assign bus.p         = p_q;
    assign bus.out_valid = valid_q;

endmodule : mult_16bit

`default_nettype wire

// File: tb/tb_mult_16bit.sv
// ============================================================================
// Module      : tb_mult_16bit
// Description : Self-checking bench for mult_16bit (directed table + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_16bit;
    import mult_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference latency model
    logic        mv [0:LATENCY-1];
    logic [31:0] mp [0:LATENCY-1];
    logic        exp_v;
    logic [31:0] exp_p;

    mult_16bit_if bus ();

    mult_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
    endtask

    // One clock: advance the model on the edge, then compare just after it.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                mv[k] = 1'b0;
                mp[k] = '0;
            end
            exp_v = 1'b0;
            exp_p = '0;
        end else begin
            for (int k = LATENCY - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                mp[k] = mp[k-1];
            end
            mv[0] = bus.in_valid;
            mp[0] = 32'(bus.a) * 32'(bus.b);
            exp_v = mv[LATENCY-1];
            if (exp_v) exp_p = mp[LATENCY-1];
        end
        #1;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
        chk("p", bus.p, exp_p);
    endtask

    vec_t vecs [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{"small_81xff", 16'h0081, 16'h00FF, 32'h0000_807F};
        vecs[1] = '{"small_ccxaa", 16'h00CC, 16'h00AA, 32'd34680};
        vecs[2] = '{"small_c0x07", 16'h00C0, 16'h0007, 32'd1344};
        vecs[3] = '{"max_ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[4] = '{"msb_8000xdddd", 16'h8000, 16'hDDDD, 32'h6EEE_8000};
        vecs[5] = '{"zero_0xffff", 16'h0000, 16'hFFFF, 32'h0000_0000};
        vecs[6] = '{"mixed_abcdx9999", 16'hABCD, 16'h9999, 32'd1729376901};
        vecs[7] = '{"mixed_ddddxffff", 16'hDDDD, 16'hFFFF, 32'hDDDC_2223};

        // Reset held with live operands: outputs must stay cleared.
        rst_n = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            mv[k] = 1'b0;
            mp[k] = '0;
        end
        exp_v = 1'b0;
        exp_p = '0;
        repeat (3) begin
            drive(1'b1, 16'($urandom), 16'($urandom));
            tick();
        end

        // in_valid on the release edge is accepted.
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, 16'h0010);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        repeat (LATENCY - 1) tick();
        chk("first_after_reset", bus.p, 32'h0001_2340);
        tick();

        // Directed table, isolated by idle cycles
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].b);
            tick();
            drive(1'b0, 16'hFFFF, 16'hFFFF);
            repeat (LATENCY - 1) tick();
            chk(vecs[i].name, bus.p, vecs[i].p);
            chk({vecs[i].name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
            tick();
            chk({vecs[i].name, "_hold"}, bus.p, vecs[i].p);
        end

        // Back-to-back stream of ten pairs
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i % 8].a ^ 16'(i * 16'h0101), vecs[(i + 3) % 8].b + 16'(i));
            tick();
        end
        drive(1'b0, 16'h0, 16'h0);
        repeat (LATENCY + 1) tick();

        // Random traffic with idle gaps and a mid-stream reset
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000 || i == 5001) rst_n = 1'b0;
            else rst_n = 1'b1;
            if ($urandom_range(0, 15) == 0)
                drive(1'b1, ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000, 16'($urandom));
            else
                drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0);
        repeat (LATENCY + 1) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mult_16bit

`default_nettype wire
